seq_match_logger: RTL and testbench
===================================

// Module: seq_match_logger
// PURPOSE
//  Downstream stage of the Mealy 1011 sequence detector. Consumes the detector's
//  per-bit match pulse (zout) and keeps a running bit index of the serial stream.
//  Pushes the index of every bit that completes a match into a small FIFO.
//  The FIFO drains over a valid/ready read port; the block also keeps a saturating
//  total match count and a sticky overflow flag.
// PARAMETERS
//  IDX_W   8  width of bit-index counter and FIFO data (wraps at 2^IDX_W)
//  DEPTH   4  FIFO entries (power of 2, >=2)
//  CNT_W   8  width of total match counter (saturating)
// PORTS
//  clk        in   1           rising-edge clock, same clock as the detector
//  rst        in   1           synchronous reset, active-low (0 = reset)
//  bit_valid  in   1           1 = a serial bit is presented to the detector this cycle
//  zout       in   1           detector match output, sampled only when bit_valid=1
//  clr        in   1           synchronous clear, active-high
//  rd_valid   out  1           FIFO non-empty (first-word fall-through)
//  rd_ready   in   1           consumer accepts rd_data when rd_valid=1
//  rd_data    out  IDX_W       bit index of oldest unread match
//  match_cnt  out  CNT_W       total matches seen since reset/clr, saturating
//  level      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//  overflow   out  1           sticky: a match was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=0 at clk edge): idx, match_cnt, level, overflow, FIFO pointers = 0.
//   rd_valid=0 and rd_data=0 from the next cycle. Reset overrides all other inputs.
//  clr=1 (rst=1): same effect as reset, same cycle. clr wins over push/pop that cycle.
//  Bit index idx:
//   - increments by 1 on every bit_valid=1 cycle, wraps 2^IDX_W-1 -> 0.
//   - The logged value is idx before that cycle's increment (first bit after reset = 0).
//  Push condition: bit_valid=1 && zout=1. zout is ignored when bit_valid=0.
//  match_cnt: +1 on every push condition, including dropped ones; holds at 2^CNT_W-1.
//  Pop condition: rd_valid=1 && rd_ready=1.
//   - rd_data is registered FIFO head, valid whenever rd_valid=1.
//   - rd_ready with rd_valid=0 has no effect.
//  Latency: an entry pushed at edge N is visible (rd_valid=1, rd_data) after edge N, i.e. cycle N+1.
//  Full (level=DEPTH) + push + pop same cycle: both happen, level unchanged, no overflow.
//  Full + push, no pop: entry dropped, FIFO unchanged, overflow<=1 (sticky until rst/clr).
//  Empty + push + pop: rd_valid=0, so no pop; push proceeds, level becomes 1.
//  Pointers wrap modulo DEPTH; level = write count minus read count, never exceeds DEPTH.
//  No combinational path from inputs to outputs; all outputs are registers or decodes of registers.
// TESTING
//  1 Reset: rst=0 for 2 cycles with zout=1, bit_valid=1 -> all outputs 0, rd_valid=0.
//  2 Detector stream 1,0,1,1,1,0,1,1, one bit/cycle, bit_valid=1, rd_ready=0:
//    zout pulses on bits 3 and 7 -> FIFO holds 3 then 7, level=2, match_cnt=2.
//  3 Drain: rd_ready=1 after test 2 -> rd_data=3, then 7, then rd_valid=0, level=0.
//  4 Overflow, DEPTH=4, rd_ready=0: 5 matches at idx 0,1,2,3,4 -> FIFO keeps 0..3,
//    overflow=1, match_cnt=5. A push and a pop in the same cycle while full -> level stays 4.
//  5 Wrap/saturate, IDX_W=3, CNT_W=3: match on bits 7 and 8 -> logged 7 then 0.
//    9 matches -> match_cnt=7.
//  6 clr mid-stream while a push is pending: level=0, overflow=0, match_cnt=0, idx=0.
//    Next bit is logged as index 0.

Source files
------------

// File: rtl/seq_match_logger_if.sv
// Read port of the match logger: first-word-fall-through valid/ready stream of
// logged bit indices. The logger drives it through the master modport.
interface seq_match_logger_if #(
   parameter int IDX_W = 8
);
   logic             rd_valid;
   logic             rd_ready;
   logic [IDX_W-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/seq_match_logger.sv
// Logs the stream bit index of every detector match into a small FWFT FIFO and
// keeps a saturating match total plus a sticky overflow flag.
module seq_match_logger #(
   parameter int IDX_W = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bit_valid,
   input  logic                    zout,
   input  logic                    clr,
   seq_match_logger_if.master      rd,
   output logic [CNT_W-1:0]        match_cnt,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [IDX_W-1:0] idx_r, idx_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [LW-1:0]    level_r, level_nxt_s;
   logic [PW-1:0]    wr_ptr_r, wr_ptr_nxt_s;
   logic [PW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
   logic             ovf_r, ovf_nxt_s;
   logic [IDX_W-1:0] mem_r [DEPTH];

   logic clear_s, push_s, pop_s, full_s, wr_en_s, rd_valid_s;

   assign clear_s    = !rst || clr;
   assign rd_valid_s = (level_r != {LW{1'b0}});
   assign push_s     = bit_valid & zout;
   assign pop_s      = rd_valid_s & rd.rd_ready;
   assign full_s     = (level_r == LW'(DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en_s    = push_s & (!full_s | pop_s);

   // Next-state computation for index, counter, pointers, occupancy and overflow
   always_comb begin
      idx_nxt_s    = idx_r;
      cnt_nxt_s    = cnt_r;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      level_nxt_s  = level_r;
      ovf_nxt_s    = ovf_r;

      if (bit_valid) begin
         idx_nxt_s = idx_r + IDX_W'(1);
      end else begin
         idx_nxt_s = idx_r;
      end

      if (push_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end

      if (push_s && full_s && !pop_s) begin
         ovf_nxt_s = 1'b1;
      end else begin
         ovf_nxt_s = ovf_r;
      end

      if (wr_en_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PW'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({wr_en_s, pop_s})
         2'b10:   level_nxt_s = level_r + LW'(1);
         2'b01:   level_nxt_s = level_r - LW'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // State registers; reset and clear share one path and beat any push/pop
   always_ff @(posedge clk) begin
      if (clear_s) begin
         idx_r    <= {IDX_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         level_r  <= {LW{1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         idx_r    <= idx_nxt_s;
         cnt_r    <= cnt_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         level_r  <= level_nxt_s;
         ovf_r    <= ovf_nxt_s;
      end
   end

   // FIFO storage; logs the index before this cycle's increment
   always_ff @(posedge clk) begin
      if (wr_en_s && !clear_s) begin
         mem_r[wr_ptr_r] <= idx_r;
      end
   end

   // Head is forced to zero while empty so stale storage never shows
   assign rd.rd_valid = rd_valid_s;
   assign rd.rd_data  = rd_valid_s ? mem_r[rd_ptr_r] : {IDX_W{1'b0}};
   assign match_cnt   = cnt_r;
   assign level       = level_r;
   assign overflow    = ovf_r;
endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: a wide (IDX_W=8, CNT_W=8) and a narrow (IDX_W=3, CNT_W=3)
// instance share stimulus and are compared against a list-based reference model.
module tb_seq_match_logger;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, bit_valid, zout, clr, rd_ready;
   logic [7:0] cnt_b;
   logic [2:0] cnt_s, lvl_b, lvl_s;
   logic       ovf_b, ovf_s;

   seq_match_logger_if #(.IDX_W(8)) rb ();
   seq_match_logger_if #(.IDX_W(3)) rs ();
   assign rb.rd_ready = rd_ready;
   assign rs.rd_ready = rd_ready;

   seq_match_logger u_big (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .zout(zout), .clr(clr),
      .rd(rb), .match_cnt(cnt_b), .level(lvl_b), .overflow(ovf_b));

   seq_match_logger #(.IDX_W(3), .DEPTH(4), .CNT_W(3)) u_small (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .zout(zout), .clr(clr),
      .rd(rs), .match_cnt(cnt_s), .level(lvl_s), .overflow(ovf_s));

   // Reference model: per instance an ordered list of logged indices
   int idx_mod [2] = '{256, 8};
   int cnt_max [2] = '{255, 7};
   int m_idx [2];
   int m_cnt [2];
   int m_len [2];
   int m_fifo [2][4];
   bit m_ovf [2];

   int vectors = 0;
   int miscompares = 0;
   logic [3:0] hist;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      vectors++;
      assert (obs === 32'(exp)) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit push, pop;
      for (int k = 0; k < 2; k++) begin
         if (!rst || clr) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_len[k] = 0; m_ovf[k] = 1'b0;
         end else begin
            push = bit_valid && zout;
            pop  = (m_len[k] > 0) && rd_ready;
            if (push && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
            if (pop) begin
               for (int j = 0; j < 3; j++) m_fifo[k][j] = m_fifo[k][j+1];
               m_len[k]--;
            end
            if (push) begin
               if (m_len[k] < 4) begin
                  m_fifo[k][m_len[k]] = m_idx[k];
                  m_len[k]++;
               end else begin
                  m_ovf[k] = 1'b1;
               end
            end
            if (bit_valid) m_idx[k] = (m_idx[k] + 1) % idx_mod[k];
         end
      end
   endtask

   task automatic check_all();
      chk("big.rd_valid", 32'(rb.rd_valid), int'(m_len[0] > 0));
      chk("big.level", 32'(lvl_b), m_len[0]);
      chk("big.match_cnt", 32'(cnt_b), m_cnt[0]);
      chk("big.overflow", 32'(ovf_b), int'(m_ovf[0]));
      if (m_len[0] > 0) chk("big.rd_data", 32'(rb.rd_data), m_fifo[0][0]);
      chk("small.rd_valid", 32'(rs.rd_valid), int'(m_len[1] > 0));
      chk("small.level", 32'(lvl_s), m_len[1]);
      chk("small.match_cnt", 32'(cnt_s), m_cnt[1]);
      chk("small.overflow", 32'(ovf_s), int'(m_ovf[1]));
      if (m_len[1] > 0) chk("small.rd_data", 32'(rs.rd_data), m_fifo[1][0]);
   endtask

   task automatic step(input bit bv, input bit z, input bit rdy, input bit c);
      bit_valid = bv; zout = z; rd_ready = rdy; clr = c;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] stream;
      stream = 8'b1101_1101;  // bits 0..7 = 1,0,1,1,1,0,1,1 (LSB first)
      rst = 1'b0; bit_valid = 1'b1; zout = 1'b1; clr = 1'b0; rd_ready = 1'b0;

      // Reset held with active inputs
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst.big.rd_data", 32'(rb.rd_data), 0);
      chk("rst.small.rd_data", 32'(rs.rd_data), 0);
      rst = 1'b1;

      // Detector stream; zout from a 4-bit history window matching 1011
      hist = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         hist = {hist[2:0], stream[i]};
         step(1'b1, hist == 4'b1011, 1'b0, 1'b0);
      end
      chk("t2.level", 32'(lvl_b), 2);
      chk("t2.match_cnt", 32'(cnt_b), 2);
      chk("t2.head", 32'(rb.rd_data), 3);

      // Drain
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3.head2", 32'(rb.rd_data), 7);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3.empty", 32'(rb.rd_valid), 0);
      chk("t3.level", 32'(lvl_b), 0);

      // Overflow with five consecutive matches, then push+pop while full
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4.overflow", 32'(ovf_b), 1);
      chk("t4.match_cnt", 32'(cnt_b), 5);
      chk("t4.level", 32'(lvl_b), 4);
      chk("t4.head", 32'(rb.rd_data), 0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t4.full_pushpop.level", 32'(lvl_b), 4);
      chk("t4.full_pushpop.head", 32'(rb.rd_data), 1);

      // Index wrap and counter saturation on the narrow instance
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5.small.head", 32'(rs.rd_data), 7);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5.small.wrapped", 32'(rs.rd_data), 0);
      chk("t5.big.head", 32'(rb.rd_data), 8);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5.small.sat", 32'(cnt_s), 7);
      chk("t5.big.cnt", 32'(cnt_b), 9);

      // Clear while a push is presented; next bit logs as index 0
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t6.level", 32'(lvl_b), 0);
      chk("t6.overflow", 32'(ovf_b), 0);
      chk("t6.match_cnt", 32'(cnt_b), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6.first_idx", 32'(rb.rd_data), 0);
      chk("t6.first_idx.small", 32'(rs.rd_data), 0);

      // Randomized traffic with occasional clear and reset
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
      end
      rst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
